// File: rtl/nes_oam_dma_if.sv
// Bus bundle between the CPU-side logic and the OAM DMA engine.
//
// Handshake: cpu_ce is a one-clock strobe on the last clk of every CPU bus
// cycle. cpu_addr, cpu_data_out, cpu_wen and cpu_ren are held stable for the
// whole bus cycle. The engine's outputs are combinational from its registered
// state and the CPU inputs, so they are constant within a bus cycle.
// cpu_rdy=0 asks the CPU to stall on its next read cycle. dma_state is a
// debug view of the engine FSM.
interface nes_oam_dma_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_wen;
  logic        cpu_ren;
  logic [7:0]  bus_data_in;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_wen;
  logic        bus_ren;
  logic        dma_active;
  logic [2:0]  dma_state;

  // CPU / system side
  modport master (
    output cpu_ce, cpu_addr, cpu_data_out, cpu_wen, cpu_ren, bus_data_in,
    input  cpu_rdy, bus_addr, bus_data_out, bus_wen, bus_ren, dma_active, dma_state
  );

  // DMA engine side
  modport slave (
    input  cpu_ce, cpu_addr, cpu_data_out, cpu_wen, cpu_ren, bus_data_in,
    output cpu_rdy, bus_addr, bus_data_out, bus_wen, bus_ren, dma_active, dma_state
  );
endinterface

// File: rtl/nes_oam_dma.sv
// NES sprite (OAM) DMA engine.
// A CPU write to TRIG_ADDR latches a source page, halts the CPU on its next
// read cycle and then copies XFER_LEN bytes from {page,count} to
// OAM_DATA_ADDR as alternating read/write bus cycles.
// Optional macro NES_OAM_DMA_ALIGN_EN: track get/put cycle parity and only
// start read cycles on get cycles (ALIGN may then last two cycles).
module nes_oam_dma #(
  parameter logic [15:0] TRIG_ADDR     = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input logic          clk,
  input logic          b_rst,
  nes_oam_dma_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_RD    = 3'd3,
    S_WR    = 3'd4
  } state_t;

  // Index of the final byte; an 8-bit compare lets XFER_LEN=256 end on the
  // natural 255 -> 0 wrap of count.
  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] page;
  logic [7:0] count;
  logic [7:0] data_q;
  logic       trig;

  assign trig          = bus.cpu_ce && bus.cpu_wen && (bus.cpu_addr == TRIG_ADDR);
  assign bus.dma_state = state;

`ifdef NES_OAM_DMA_ALIGN_EN
  logic parity;  // 0 = get cycle, 1 = put cycle

  // Free-running get/put parity, advancing once per CPU bus cycle
  always_ff @(posedge clk) begin
    if (!b_rst) parity <= 1'b0;
    else if (bus.cpu_ce) parity <= ~parity;
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!b_rst) state <= S_IDLE;
    else state <= state_nx;
  end

  // Page/count/data registers, updated only at the end of a bus cycle
  always_ff @(posedge clk) begin
    if (!b_rst) begin
      page   <= 8'h00;
      count  <= 8'h00;
      data_q <= 8'h00;
    end else begin
      if (state == S_IDLE && trig) begin
        page  <= bus.cpu_data_out;
        count <= 8'h00;
      end
      if (state == S_RD && bus.cpu_ce) data_q <= bus.bus_data_in;
      if (state == S_WR && bus.cpu_ce) count <= count + 8'd1;
    end
  end

  // Next-state and bus multiplexing; the CPU owns the bus unless overridden
  always_comb begin
    state_nx         = state;
    bus.bus_addr     = bus.cpu_addr;
    bus.bus_data_out = bus.cpu_data_out;
    bus.bus_wen      = bus.cpu_wen;
    bus.bus_ren      = bus.cpu_ren;
    bus.cpu_rdy      = 1'b1;
    bus.dma_active   = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig) state_nx = S_HALT;
      end
      S_HALT: begin
        // The CPU cannot be stalled on a write, so wait for its first read.
        bus.cpu_rdy = 1'b0;
        if (bus.cpu_ce && bus.cpu_ren && !bus.cpu_wen) state_nx = S_ALIGN;
      end
      S_ALIGN: begin
        bus.cpu_rdy    = 1'b0;
        bus.dma_active = 1'b1;
        bus.bus_addr   = {page, count};
        bus.bus_wen    = 1'b0;
        bus.bus_ren    = 1'b0;
`ifdef NES_OAM_DMA_ALIGN_EN
        // A put cycle now means the next cycle is a get cycle.
        if (bus.cpu_ce && parity) state_nx = S_RD;
`else
        if (bus.cpu_ce) state_nx = S_RD;
`endif
      end
      S_RD: begin
        bus.cpu_rdy    = 1'b0;
        bus.dma_active = 1'b1;
        bus.bus_addr   = {page, count};
        bus.bus_wen    = 1'b0;
        bus.bus_ren    = 1'b1;
        if (bus.cpu_ce) state_nx = S_WR;
      end
      S_WR: begin
        bus.cpu_rdy      = 1'b0;
        bus.dma_active   = 1'b1;
        bus.bus_addr     = OAM_DATA_ADDR;
        bus.bus_data_out = data_q;
        bus.bus_wen      = 1'b1;
        bus.bus_ren      = 1'b0;
        if (bus.cpu_ce) state_nx = (count == LAST) ? S_IDLE : S_RD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Self-checking bench for nes_oam_dma (default length) plus a one-byte
// instance. Reference model: on each accepted trigger the expected DMA is
// planned up front as a queue of per-cycle bus records.
module tb_nes_oam_dma;

  localparam logic [15:0] TRIG     = 16'h4014;
  localparam logic [15:0] OAM      = 16'h2004;
  localparam int          XFER_LEN = 256;

  typedef struct {
    logic        rdy;
    logic        active;
    logic        wen;
    logic        ren;
    logic        chk_addr;
    logic [15:0] addr;
    logic        chk_data;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        wen;
    logic        ren;
    logic        exp_rdy;
    logic        exp_active;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic b_rst = 1'b0;
  logic en1 = 1'b0;
  logic rst1;
  always #5 clk = ~clk;
  assign rst1 = b_rst & en1;

  nes_oam_dma_if cif ();
  nes_oam_dma_if cif1 ();

  assign cif1.cpu_ce       = cif.cpu_ce;
  assign cif1.cpu_addr     = cif.cpu_addr;
  assign cif1.cpu_data_out = cif.cpu_data_out;
  assign cif1.cpu_wen      = cif.cpu_wen;
  assign cif1.cpu_ren      = cif.cpu_ren;
  assign cif1.bus_data_in  = cif.bus_data_in;

  nes_oam_dma dut (.clk(clk), .b_rst(b_rst), .bus(cif));
  nes_oam_dma #(.XFER_LEN(1)) dut1 (.clk(clk), .b_rst(rst1), .bus(cif1));

  // ---------------- scoreboard / model state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mem [65536];
  exp_t        exp_q [$];
  logic        m_pending = 1'b0;
  logic [7:0]  m_page = 8'h00;
  int          ce_count = 0;

  logic        s_rdy, s_act, s_wen, s_ren;
  logic [15:0] s_addr;
  logic [7:0]  s_dout;
  logic        s1_rdy, s1_act;
  int          d1_rd, d1_wr, d1_low;
  logic [15:0] d1_rd_addr, d1_wr_addr;
  logic [7:0]  d1_wr_data;

  task automatic check(input string nm, input logic ok, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Plan the whole transfer once the dummy (halt) read cycle is known.
  function automatic void build_plan();
    exp_t e;
    int   al;
    al = 1;
`ifdef NES_OAM_DMA_ALIGN_EN
    // The cycle after the dummy read is the first ALIGN cycle; if it is a
    // get cycle the read must wait one more cycle.
    if (((ce_count + 1) % 2) == 0) al = 2;
`endif
    for (int i = 0; i < al; i++) begin
      e = '{rdy:1'b0, active:1'b1, wen:1'b0, ren:1'b0, chk_addr:1'b0, addr:16'h0, chk_data:1'b0, data:8'h0};
      exp_q.push_back(e);
    end
    for (int i = 0; i < XFER_LEN; i++) begin
      e = '{rdy:1'b0, active:1'b1, wen:1'b0, ren:1'b1, chk_addr:1'b1, addr:{m_page, 8'(i)}, chk_data:1'b0, data:8'h0};
      exp_q.push_back(e);
      e = '{rdy:1'b0, active:1'b1, wen:1'b1, ren:1'b0, chk_addr:1'b1, addr:OAM, chk_data:1'b1, data:mem[{m_page, 8'(i)}]};
      exp_q.push_back(e);
    end
  endfunction

  // ---------------- driver: one CPU bus cycle of 1..3 clks ----------------
  task automatic do_cycle(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
    exp_t       e;
    logic       from_plan;
    logic       ok;
    logic [7:0] bi;
    int         n;
    from_plan = (exp_q.size() > 0);
    if (from_plan) e = exp_q.pop_front();
    else e = '{rdy:!m_pending, active:1'b0, wen:w, ren:r, chk_addr:1'b1, addr:a, chk_data:1'b1, data:d};
    bi = (from_plan && e.ren) ? mem[e.addr] : 8'($urandom_range(0, 255));
    cif.cpu_addr     = a;
    cif.cpu_data_out = d;
    cif.cpu_wen      = w;
    cif.cpu_ren      = r;
    cif.bus_data_in  = bi;
    n = $urandom_range(1, 3);
    for (int k = 0; k < n; k++) begin
      cif.cpu_ce = (k == n - 1);
      @(negedge clk);
      s_rdy  = cif.cpu_rdy;
      s_act  = cif.dma_active;
      s_wen  = cif.bus_wen;
      s_ren  = cif.bus_ren;
      s_addr = cif.bus_addr;
      s_dout = cif.bus_data_out;
      s1_rdy = cif1.cpu_rdy;
      s1_act = cif1.dma_active;
      if (en1 && k == n - 1) begin
        if (!cif1.cpu_rdy) d1_low++;
        if (cif1.dma_active && cif1.bus_ren) begin d1_rd++; d1_rd_addr = cif1.bus_addr; end
        if (cif1.dma_active && cif1.bus_wen) begin
          d1_wr++; d1_wr_addr = cif1.bus_addr; d1_wr_data = cif1.bus_data_out;
        end
      end
      @(posedge clk);
      #1;
    end
    cif.cpu_ce = 1'b0;
    ok = (s_rdy == e.rdy) && (s_act == e.active) && (s_wen == e.wen) && (s_ren == e.ren) &&
         (!e.chk_addr || s_addr == e.addr) && (!e.chk_data || s_dout == e.data);
    check("bus_cycle", ok, {4'h0, s_rdy, s_act, s_wen, s_ren, s_addr, s_dout},
          {4'h0, e.rdy, e.active, e.wen, e.ren, e.addr, e.data});
    if (!from_plan) begin
      if (m_pending) begin
        if (r && !w) begin
          build_plan();
          m_pending = 1'b0;
        end
      end else if (w && a == TRIG) begin
        m_pending = 1'b1;
        m_page    = d;
      end
    end
    ce_count++;
  endtask

  task automatic do_reset(input logic with_trig);
    cif.cpu_ce       = with_trig;
    cif.cpu_wen      = with_trig;
    cif.cpu_ren      = !with_trig;
    cif.cpu_addr     = TRIG;
    cif.cpu_data_out = 8'h66;
    cif.bus_data_in  = 8'h00;
    b_rst = 1'b0;
    @(posedge clk);
    #1;
    b_rst = 1'b1;
    cif.cpu_ce = 1'b0;
    exp_q.delete();
    m_pending = 1'b0;
    ce_count  = 0;
    @(negedge clk);
    check("reset_state", cif.cpu_rdy && !cif.dma_active && cif.bus_addr == TRIG,
          {14'h0, cif.cpu_rdy, cif.dma_active, cif.bus_addr}, {14'h0, 1'b1, 1'b0, TRIG});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 1200 && !done; k++) begin
      do_cycle(16'hE000 + 16'(k), 8'h00, 1'b0, 1'b1);
      if (s_rdy) done = 1'b1;
    end
    check({nm, "_drain"}, done, 32'(done), 32'd1);
  endtask

  // Trigger on a chosen parity, optional write stalls, then CPU reads until
  // released; halt length is derived from the cycle rules.
  task automatic dma_seq(input string nm, input logic [7:0] pg, input int want_par,
                         input int n_stall, input logic force_trig);
    int   low;
    int   exp_low;
    int   dummy_idx;
    int   al;
    logic done;
    if ((ce_count % 2) != want_par) do_cycle(16'h8000, 8'h00, 1'b0, 1'b1);
    do_cycle(TRIG, pg, 1'b1, 1'b0);
    low = 0;
    for (int s = 0; s < n_stall; s++) begin
      do_cycle(16'h0100 + 16'(s), 8'(s), 1'b1, 1'b0);
      if (!s_rdy) low++;
    end
    dummy_idx = ce_count;
    al = 1;
`ifdef NES_OAM_DMA_ALIGN_EN
    if (((dummy_idx + 1) % 2) == 0) al = 2;
`endif
    exp_low = n_stall + 1 + al + 2 * XFER_LEN;
    done = 1'b0;
    for (int k = 0; k < 1200 && !done; k++) begin
      if (force_trig && k > 2 && k < 2 * XFER_LEN && (k % 2) == 1)
        do_cycle(TRIG, 8'h55, 1'b1, 1'b0);
      else
        do_cycle(16'hC000 + 16'(k), 8'h00, 1'b0, 1'b1);
      if (s_rdy) done = 1'b1;
      else low++;
    end
    check({nm, "_done"}, done, 32'(done), 32'd1);
    check({nm, "_halt_len"}, low == exp_low, 32'(low), 32'(exp_low));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    logic ok;
    int   al1;
    logic [15:0] ra;
    logic        rw;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
    cif.cpu_ce = 1'b0; cif.cpu_addr = 16'h0; cif.cpu_data_out = 8'h0;
    cif.cpu_wen = 1'b0; cif.cpu_ren = 1'b0; cif.bus_data_in = 8'h0;

    do_reset(1'b0);

    // IDLE pass-through table, ending with a trigger and a write in HALT
    vecs[0] = '{16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{16'h4015, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'h2004, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h4014, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFC, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h4014, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'h1234, 8'h9C, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_cycle(vecs[i].addr, vecs[i].data, vecs[i].wen, vecs[i].ren);
      ok = (s_rdy == vecs[i].exp_rdy) && (s_act == vecs[i].exp_active) && (s_addr == vecs[i].addr) &&
           (s_wen == vecs[i].wen) && (s_ren == vecs[i].ren) && (s_dout == vecs[i].data);
      check($sformatf("vec%0d", i), ok, {4'h0, s_rdy, s_act, s_wen, s_ren, s_addr, s_dout},
            {4'h0, vecs[i].exp_rdy, vecs[i].exp_active, vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].data});
    end
    drain("table");

    dma_seq("get", 8'h02, 0, 0, 1'b0);
    dma_seq("put", 8'h02, 1, 0, 1'b0);
    dma_seq("stall2", 8'h07, 0, 2, 1'b0);
    dma_seq("forced_trig", 8'h11, 1, 0, 1'b1);

    // Reset in the middle of a transfer, then restart from count 0
    do_cycle(TRIG, 8'h03, 1'b1, 1'b0);
    for (int k = 0; k < 202; k++) do_cycle(16'hA000, 8'h00, 1'b0, 1'b1);
    do_reset(1'b0);
    dma_seq("after_rst", 8'h04, 0, 0, 1'b0);

    // Reset coinciding with a trigger strobe must leave the engine idle
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) do_cycle(16'h0300 + 16'(k), 8'h00, 1'b0, 1'b1);

    // One-byte instance: single read of FF00, single write to OAM data
    en1 = 1'b1;
    do_reset(1'b0);
    d1_rd = 0; d1_wr = 0; d1_low = 0;
    d1_rd_addr = 16'h0; d1_wr_addr = 16'h0; d1_wr_data = 8'h0;
    dma_seq("len256_ff", 8'hFF, 0, 0, 1'b0);
    al1 = 1;
`ifdef NES_OAM_DMA_ALIGN_EN
    al1 = 2;
`endif
    check("len1_reads", d1_rd == 1 && d1_rd_addr == 16'hFF00, {d1_rd[15:0], d1_rd_addr}, {16'd1, 16'hFF00});
    check("len1_writes", d1_wr == 1 && d1_wr_addr == OAM && d1_wr_data == mem[16'hFF00],
          {d1_wr[7:0], d1_wr_addr, d1_wr_data}, {8'd1, OAM, mem[16'hFF00]});
    check("len1_halt_len", d1_low == 1 + al1 + 2, 32'(d1_low), 32'(1 + al1 + 2));
    check("len1_idle", s1_rdy && !s1_act, {30'h0, s1_rdy, s1_act}, {30'h0, 1'b1, 1'b0});
    en1 = 1'b0;

    // Randomised traffic with occasional triggers, also while a DMA runs
    for (int i = 0; i < 1500; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) begin ra = TRIG; rw = 1'b1; end
      do_cycle(ra, 8'($urandom_range(0, 255)), rw, !rw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
